// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_pkg
// Description : Shared types and default widths for the dual-mode SlugTPU
//               processing element (weight-stationary / output-stationary).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Contents    : pe_mode_e  - dataflow selected by mode_i
//               pe_state_e - PE control state
//               c_default_* - default parameter values
// ============================================================================
package pe_pkg;

    localparam int c_default_input_width  = 8;
    localparam int c_default_weight_width = 8;
    localparam int c_default_psum_width   = 32;
    localparam int c_default_saturate     = 1;

    typedef enum logic {
        PE_MODE_WS = 1'b0,
        PE_MODE_OS = 1'b1
    } pe_mode_e;

    typedef enum logic [1:0] {
        S_WS       = 2'd0,
        S_OS_ACC   = 2'd1,
        S_OS_DRAIN = 2'd2
    } pe_state_e;

endpackage : pe_pkg
`default_nettype wire

// File: rtl/pe_sat_add.sv
`default_nettype none
// ============================================================================
// Module      : pe_sat_add
// Description : Combinational signed add of a psum/accumulator and a product.
//               The sum is formed one bit wider than the psum; an overflow is
//               flagged when the two top bits disagree, and the result is then
//               either clamped (SATURATE=1) or truncated (SATURATE=0).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : a_i   [PSUM_WIDTH] signed addend (psum or accumulator)
//               b_i   [PROD_WIDTH] signed product
//               sum_o [PSUM_WIDTH] result after clamp/wrap
//               ovf_o              result did not fit in PSUM_WIDTH bits
// ============================================================================
module pe_sat_add #(
    parameter int PSUM_WIDTH = 32,
    parameter int PROD_WIDTH = 16,
    parameter int SATURATE   = 1
) (
    input  logic [PSUM_WIDTH-1:0] a_i,
    input  logic [PROD_WIDTH-1:0] b_i,
    output logic [PSUM_WIDTH-1:0] sum_o,
    output logic                  ovf_o
);

    localparam int c_ext = PSUM_WIDTH + 1 - PROD_WIDTH;

    logic [PSUM_WIDTH:0] w_wide;

    assign w_wide = {a_i[PSUM_WIDTH-1], a_i} + {{c_ext{b_i[PROD_WIDTH-1]}}, b_i};
    assign ovf_o  = w_wide[PSUM_WIDTH] ^ w_wide[PSUM_WIDTH-1];

    generate
        if (SATURATE != 0) begin : g_sat
            // The extra top bit holds the true sign, which picks the rail.
            always_comb begin
                if (ovf_o) begin
                    sum_o = w_wide[PSUM_WIDTH] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}}
                                               : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
                end else begin
                    sum_o = w_wide[PSUM_WIDTH-1:0];
                end
            end
        end else begin : g_wrap
            assign sum_o = w_wide[PSUM_WIDTH-1:0];
        end
    endgenerate

endmodule : pe_sat_add
`default_nettype wire

// File: rtl/pe_dualmode.sv
`default_nettype none
// ============================================================================
// Module      : pe_dualmode
// Description : One MAC cell of the SlugTPU array supporting weight-stationary
//               and output-stationary dataflows. Double-buffered weights with a
//               column-wide swap, saturating/wrapping accumulate with a sticky
//               overflow flag, and an OS accumulator drained down the psum
//               chain. Activations flow east; weights, psums and swap south.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : clk_i, rst_ni (sync, active-low)
//               mode_i            0 = WS, 1 = OS (quasi-static)
//               pe_clear_i        zero accumulator and overflow flag
//               pe_drain_i        OS drain request (whole column)
//               pe_input_*_i/o    activation chain, west -> east
//               pe_weight_*_i/o   weight chain (shadow register), north -> south
//               pe_swap_i/o       shadow -> active weight swap, north -> south
//               pe_psum_*_i/o     partial-sum chain, north -> south
//               pe_ovf_o          sticky overflow/saturation event
// ============================================================================
module pe_dualmode
    import pe_pkg::*;
#(
    parameter int INPUT_WIDTH  = c_default_input_width,
    parameter int WEIGHT_WIDTH = c_default_weight_width,
    parameter int PSUM_WIDTH   = c_default_psum_width,
    parameter int SATURATE     = c_default_saturate
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    mode_i,
    input  logic                    pe_clear_i,
    input  logic                    pe_drain_i,
    input  logic [INPUT_WIDTH-1:0]  pe_input_i,
    input  logic                    pe_input_valid_i,
    output logic [INPUT_WIDTH-1:0]  pe_input_o,
    output logic                    pe_input_valid_o,
    input  logic [WEIGHT_WIDTH-1:0] pe_weight_i,
    input  logic                    pe_weight_valid_i,
    output logic [WEIGHT_WIDTH-1:0] pe_weight_o,
    output logic                    pe_weight_valid_o,
    input  logic                    pe_swap_i,
    output logic                    pe_swap_o,
    input  logic [PSUM_WIDTH-1:0]   pe_psum_i,
    input  logic                    pe_psum_valid_i,
    output logic [PSUM_WIDTH-1:0]   pe_psum_o,
    output logic                    pe_psum_valid_o,
    output logic                    pe_ovf_o
);

    localparam int c_prod_width = INPUT_WIDTH + WEIGHT_WIDTH;

    pe_mode_e                  r_mode;
    pe_state_e                 r_state;
    logic [INPUT_WIDTH-1:0]    r_input;
    logic                      r_input_valid;
    logic [WEIGHT_WIDTH-1:0]   r_w_sh;
    logic [WEIGHT_WIDTH-1:0]   r_w_act;
    logic                      r_weight_valid;
    logic                      r_swap;
    logic [PSUM_WIDTH-1:0]     r_psum;
    logic                      r_psum_valid;
    logic [PSUM_WIDTH-1:0]     r_acc;
    logic                      r_ovf;

    pe_mode_e                  w_mode_in;
    logic                      w_is_ws;
    logic                      w_os_fire;
    logic [WEIGHT_WIDTH-1:0]   w_mul_w;
    logic signed [c_prod_width-1:0] w_prod;
    logic [PSUM_WIDTH-1:0]     w_add_a;
    logic [PSUM_WIDTH-1:0]     w_sum;
    logic                      w_sum_ovf;
    logic [PSUM_WIDTH-1:0]     w_acc_next;

    assign w_mode_in = pe_mode_e'(mode_i);
    assign w_is_ws   = (r_state == S_WS);
    assign w_os_fire = pe_input_valid_i && pe_weight_valid_i;

    // Only one dataflow is active at a time, so a single multiplier and adder
    // serve both: WS multiplies by the active weight and adds the incoming
    // psum, OS multiplies by the streaming weight and adds the accumulator.
    assign w_mul_w = w_is_ws ? r_w_act : pe_weight_i;
    assign w_prod  = $signed(pe_input_i) * $signed(w_mul_w);
    assign w_add_a = w_is_ws ? (pe_psum_valid_i ? pe_psum_i : '0) : r_acc;

    pe_sat_add #(
        .PSUM_WIDTH (PSUM_WIDTH),
        .PROD_WIDTH (c_prod_width),
        .SATURATE   (SATURATE)
    ) u_sat_add (
        .a_i   (w_add_a),
        .b_i   (w_prod),
        .sum_o (w_sum),
        .ovf_o (w_sum_ovf)
    );

    assign w_acc_next = w_os_fire ? w_sum : r_acc;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_mode         <= PE_MODE_WS;
            r_state        <= S_WS;
            r_input        <= '0;
            r_input_valid  <= 1'b0;
            r_w_sh         <= '0;
            r_w_act        <= '0;
            r_weight_valid <= 1'b0;
            r_swap         <= 1'b0;
            r_psum         <= '0;
            r_psum_valid   <= 1'b0;
            r_acc          <= '0;
            r_ovf          <= 1'b0;
        end else begin
            r_mode         <= w_mode_in;
            r_input        <= pe_input_i;
            r_input_valid  <= pe_input_valid_i;
            r_weight_valid <= pe_weight_valid_i;
            r_swap         <= pe_swap_i;

            if (pe_weight_valid_i) begin
                r_w_sh <= pe_weight_i;
            end
            // Reads the pre-update shadow so a same-cycle load is not swapped in.
            if (pe_swap_i) begin
                r_w_act <= r_w_sh;
            end

            case (r_state)
                S_WS: begin
                    if (pe_input_valid_i) begin
                        r_psum <= w_sum;
                        if (w_sum_ovf) begin
                            r_ovf <= 1'b1;
                        end
                    end
                    r_psum_valid <= pe_input_valid_i;
                end
                S_OS_ACC: begin
                    if (w_os_fire && w_sum_ovf) begin
                        r_ovf <= 1'b1;
                    end
                    if (pe_drain_i) begin
                        // Emit including any same-cycle MAC, then restart.
                        r_psum       <= w_acc_next;
                        r_psum_valid <= 1'b1;
                        r_acc        <= '0;
                        r_state      <= S_OS_DRAIN;
                    end else begin
                        r_psum_valid <= 1'b0;
                        r_acc        <= w_acc_next;
                    end
                end
                S_OS_DRAIN: begin
                    // Pass the rows above through while the fresh acc keeps going.
                    r_psum       <= pe_psum_i;
                    r_psum_valid <= pe_psum_valid_i;
                    r_acc        <= w_acc_next;
                    if (w_os_fire && w_sum_ovf) begin
                        r_ovf <= 1'b1;
                    end
                    if (!pe_drain_i) begin
                        r_state <= S_OS_ACC;
                    end
                end
                default: begin
                    r_state <= S_WS;
                end
            endcase

            if (pe_clear_i) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end

            if (w_mode_in != r_mode) begin
                r_state <= (w_mode_in == PE_MODE_OS) ? S_OS_ACC : S_WS;
                r_acc   <= '0;
                r_ovf   <= 1'b0;
            end
        end
    end

    assign pe_input_o        = r_input;
    assign pe_input_valid_o  = r_input_valid;
    assign pe_weight_o       = r_w_sh;
    assign pe_weight_valid_o = r_weight_valid;
    assign pe_swap_o         = r_swap;
    assign pe_psum_o         = r_psum;
    assign pe_psum_valid_o   = r_psum_valid;
    assign pe_ovf_o          = r_ovf;

endmodule : pe_dualmode
`default_nettype wire

// File: tb/tb_pe_dualmode.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_dualmode
// Description : Self-checking bench for pe_dualmode. Two 16-bit-psum
//               instances (clamping and wrapping) share one stimulus stream;
//               each is compared every cycle against an arithmetic model that
//               works on plain integers, plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_dualmode;

    localparam int c_pw = 16;

    typedef struct {
        logic [7:0]  in_o;
        bit          in_v;
        logic [7:0]  w_sh;
        bit          w_v;
        bit          swap;
        logic [15:0] psum;
        bit          pv;
        bit          ovf;
        logic [7:0]  w_act;
        bit          mode;
        bit          draining;
        longint      acc;
    } model_t;

    logic        r_clk;
    logic        r_rst_n;
    logic        r_mode;
    logic        r_clear;
    logic        r_drain;
    logic [7:0]  r_in;
    logic        r_in_v;
    logic [7:0]  r_w;
    logic        r_w_v;
    logic        r_swap;
    logic [15:0] r_psum;
    logic        r_psum_v;

    logic [7:0]  w_s_in,   w_r_in;
    logic        w_s_in_v, w_r_in_v;
    logic [7:0]  w_s_w,    w_r_w;
    logic        w_s_w_v,  w_r_w_v;
    logic        w_s_swap, w_r_swap;
    logic [15:0] w_s_psum, w_r_psum;
    logic        w_s_pv,   w_r_pv;
    logic        w_s_ovf,  w_r_ovf;

    int     total;
    int     bad;
    model_t m_s;
    model_t m_r;

    pe_dualmode #(.INPUT_WIDTH(8), .WEIGHT_WIDTH(8), .PSUM_WIDTH(c_pw), .SATURATE(1)) u_sat (
        .clk_i(r_clk), .rst_ni(r_rst_n), .mode_i(r_mode), .pe_clear_i(r_clear),
        .pe_drain_i(r_drain), .pe_input_i(r_in), .pe_input_valid_i(r_in_v),
        .pe_input_o(w_s_in), .pe_input_valid_o(w_s_in_v), .pe_weight_i(r_w),
        .pe_weight_valid_i(r_w_v), .pe_weight_o(w_s_w), .pe_weight_valid_o(w_s_w_v),
        .pe_swap_i(r_swap), .pe_swap_o(w_s_swap), .pe_psum_i(r_psum),
        .pe_psum_valid_i(r_psum_v), .pe_psum_o(w_s_psum), .pe_psum_valid_o(w_s_pv),
        .pe_ovf_o(w_s_ovf)
    );

    pe_dualmode #(.INPUT_WIDTH(8), .WEIGHT_WIDTH(8), .PSUM_WIDTH(c_pw), .SATURATE(0)) u_wrap (
        .clk_i(r_clk), .rst_ni(r_rst_n), .mode_i(r_mode), .pe_clear_i(r_clear),
        .pe_drain_i(r_drain), .pe_input_i(r_in), .pe_input_valid_i(r_in_v),
        .pe_input_o(w_r_in), .pe_input_valid_o(w_r_in_v), .pe_weight_i(r_w),
        .pe_weight_valid_i(r_w_v), .pe_weight_o(w_r_w), .pe_weight_valid_o(w_r_w_v),
        .pe_swap_i(r_swap), .pe_swap_o(w_r_swap), .pe_psum_i(r_psum),
        .pe_psum_valid_i(r_psum_v), .pe_psum_o(w_r_psum), .pe_psum_valid_o(w_r_pv),
        .pe_ovf_o(w_r_ovf)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    // Exact integer result squeezed into 16 bits: clamp or wrap, flag overflow.
    function automatic longint fit(input longint x, input bit sat, output bit o);
        logic [15:0] t;
        o = (x > 32767) || (x < -32768);
        if (!o) return x;
        if (sat) return (x > 0) ? 64'sd32767 : -64'sd32768;
        t = x[15:0];
        return longint'($signed(t));
    endfunction

    function automatic longint mul(input logic [7:0] a, input logic [7:0] b);
        return longint'($signed(a)) * longint'($signed(b));
    endfunction

    function automatic model_t next_model(input model_t m, input bit sat);
        model_t n;
        longint r;
        longint pin;
        bit     o;
        n = m;
        if (!r_rst_n) begin
            n = '{default: 0};
            return n;
        end
        n.in_o = r_in;
        n.in_v = r_in_v;
        n.w_v  = r_w_v;
        n.swap = r_swap;
        if (r_w_v)  n.w_sh  = r_w;
        if (r_swap) n.w_act = m.w_sh;
        if (!m.mode) begin
            if (r_in_v) begin
                pin = r_psum_v ? longint'($signed(r_psum)) : 0;
                r = fit(pin + mul(r_in, m.w_act), sat, o);
                n.psum = r[15:0];
                if (o) n.ovf = 1'b1;
            end
            n.pv = r_in_v;
        end else begin
            r = m.acc;
            if (r_in_v && r_w_v) begin
                r = fit(m.acc + mul(r_in, r_w), sat, o);
                if (o) n.ovf = 1'b1;
            end
            if (!m.draining) begin
                if (r_drain) begin
                    n.psum = r[15:0];
                    n.pv = 1'b1;
                    n.acc = 0;
                    n.draining = 1'b1;
                end else begin
                    n.pv = 1'b0;
                    n.acc = r;
                end
            end else begin
                n.psum = r_psum;
                n.pv = r_psum_v;
                n.acc = r;
                if (!r_drain) n.draining = 1'b0;
            end
        end
        if (r_clear) begin
            n.acc = 0;
            n.ovf = 1'b0;
        end
        if (r_mode != m.mode) begin
            n.mode = r_mode;
            n.draining = 1'b0;
            n.acc = 0;
            n.ovf = 1'b0;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("sat.psum",  32'(w_s_psum), 32'(m_s.psum));
        chk("sat.pv",    32'(w_s_pv),   32'(m_s.pv));
        chk("sat.ovf",   32'(w_s_ovf),  32'(m_s.ovf));
        chk("sat.in",    32'(w_s_in),   32'(m_s.in_o));
        chk("sat.in_v",  32'(w_s_in_v), 32'(m_s.in_v));
        chk("sat.w",     32'(w_s_w),    32'(m_s.w_sh));
        chk("sat.w_v",   32'(w_s_w_v),  32'(m_s.w_v));
        chk("sat.swap",  32'(w_s_swap), 32'(m_s.swap));
        chk("wrap.psum", 32'(w_r_psum), 32'(m_r.psum));
        chk("wrap.pv",   32'(w_r_pv),   32'(m_r.pv));
        chk("wrap.ovf",  32'(w_r_ovf),  32'(m_r.ovf));
        chk("wrap.in",   32'(w_r_in),   32'(m_r.in_o));
        chk("wrap.in_v", 32'(w_r_in_v), 32'(m_r.in_v));
        chk("wrap.w",    32'(w_r_w),    32'(m_r.w_sh));
        chk("wrap.w_v",  32'(w_r_w_v),  32'(m_r.w_v));
        chk("wrap.swap", 32'(w_r_swap), 32'(m_r.swap));
    endtask

    task automatic step();
        @(posedge r_clk);
        m_s = next_model(m_s, 1'b1);
        m_r = next_model(m_r, 1'b0);
        #1;
        check_all();
    endtask

    task automatic idle();
        r_clear  = 1'b0;
        r_drain  = 1'b0;
        r_in     = '0;
        r_in_v   = 1'b0;
        r_w      = '0;
        r_w_v    = 1'b0;
        r_swap   = 1'b0;
        r_psum   = '0;
        r_psum_v = 1'b0;
    endtask

    task automatic rand_block(input int n);
        for (int i = 0; i < n; i++) begin
            r_in     = 8'($urandom);
            r_in_v   = 1'($urandom);
            r_w      = 8'($urandom);
            r_w_v    = 1'($urandom);
            r_swap   = ($urandom_range(0, 3) == 0);
            r_psum   = 16'($urandom);
            r_psum_v = 1'($urandom);
            r_clear  = ($urandom_range(0, 15) == 0);
            r_drain  = ($urandom_range(0, 3) == 0);
            step();
        end
        idle();
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_s   = '{default: 0};
        m_r   = '{default: 0};
        idle();
        r_mode  = 1'b0;
        r_rst_n = 1'b0;
        step();
        step();
        chk("rst.psum", 32'(w_s_psum), 32'd0);
        chk("rst.ovf",  32'(w_r_ovf),  32'd0);
        r_rst_n = 1'b1;

        // WS basic: 100 + (-4 * 3) = 88
        r_w = 8'd3; r_w_v = 1'b1; step();
        r_w_v = 1'b0; r_swap = 1'b1; step();
        r_swap = 1'b0; r_in = 8'hFC; r_in_v = 1'b1; r_psum = 16'd100; r_psum_v = 1'b1; step();
        chk("ws_basic.psum", 32'(w_s_psum), 32'd88);
        chk("ws_basic.pv",   32'(w_s_pv),   32'd1);
        idle(); step();

        // Swap/load race: active weight takes the old shadow value 5
        r_w = 8'd5; r_w_v = 1'b1; step();
        r_w = 8'd9; r_swap = 1'b1; step();
        r_w_v = 1'b0; r_swap = 1'b0; r_in = 8'd2; r_in_v = 1'b1; step();
        chk("race.psum", 32'(w_s_psum), 32'd10);
        chk("race.w",    32'(w_s_w),    32'd9);
        idle(); step();

        // Saturation: 32760 + 127*127 = 48889
        r_w = 8'd127; r_w_v = 1'b1; step();
        r_w_v = 1'b0; r_swap = 1'b1; step();
        r_swap = 1'b0; r_in = 8'd127; r_in_v = 1'b1; r_psum = 16'd32760; r_psum_v = 1'b1; step();
        chk("sat.clamp",    32'(w_s_psum), 32'd32767);
        chk("sat.ovf_set",  32'(w_s_ovf),  32'd1);
        chk("wrap.value",   32'(w_r_psum), 32'h0000_BEF9);
        chk("wrap.ovf_set", 32'(w_r_ovf),  32'd1);
        idle();
        r_clear = 1'b1; step();
        chk("clear.ovf", 32'(w_s_ovf), 32'd0);
        r_clear = 1'b0;

        // OS accumulate 1+4+9+16 = 30, then drain with two rows above
        r_mode = 1'b1; step(); step();
        for (int i = 1; i <= 4; i++) begin
            r_in = 8'(i); r_w = 8'(i); r_in_v = 1'b1; r_w_v = 1'b1; step();
        end
        idle();
        r_drain = 1'b1; step();
        chk("drain.own", 32'(w_s_psum), 32'd30);
        r_psum = 16'd7; r_psum_v = 1'b1; step();
        chk("drain.row1", 32'(w_s_psum), 32'd7);
        r_psum = 16'd8; step();
        chk("drain.row2", 32'(w_s_psum), 32'd8);
        chk("drain.pv",   32'(w_s_pv),   32'd1);
        r_drain = 1'b0; r_psum_v = 1'b0; step();
        r_drain = 1'b1; step();
        chk("drain.acc_zero", 32'(w_s_psum), 32'd0);
        r_drain = 1'b0; step();

        // Overflow the accumulator, then clear wins over a same-cycle MAC
        r_in = 8'd127; r_w = 8'd127; r_in_v = 1'b1; r_w_v = 1'b1;
        step(); step(); step();
        chk("os.ovf", 32'(w_s_ovf), 32'd1);
        r_in = 8'd5; r_w = 8'd5; r_clear = 1'b1; step();
        chk("clrprio.ovf", 32'(w_s_ovf), 32'd0);
        idle();
        r_drain = 1'b1; step();
        chk("clrprio.acc", 32'(w_s_psum), 32'd0);
        r_drain = 1'b0; step();

        // Randomized traffic in OS, then in WS
        rand_block(250);
        r_mode = 1'b0; step(); step();
        rand_block(250);

        // Reset in the middle of a drain
        r_mode = 1'b1; step(); step();
        r_in = 8'd3; r_w = 8'd3; r_in_v = 1'b1; r_w_v = 1'b1; step();
        idle();
        r_drain = 1'b1; step(); step();
        r_rst_n = 1'b0; step();
        chk("rstdrain.psum", 32'(w_s_psum), 32'd0);
        chk("rstdrain.pv",   32'(w_s_pv),   32'd0);
        chk("rstdrain.w",    32'(w_s_w),    32'd0);
        // Back in WS after reset: a valid input yields a valid psum at once
        r_rst_n = 1'b1; r_drain = 1'b0;
        r_in = 8'd4; r_in_v = 1'b1; r_psum = 16'd11; r_psum_v = 1'b1; step();
        chk("rstdrain.ws_psum", 32'(w_s_psum), 32'd11);
        chk("rstdrain.ws_pv",   32'(w_s_pv),   32'd1);
        idle(); step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pe_dualmode
`default_nettype wire

// File: doc/pe_dualmode.md
# pe_dualmode

Parametrised successor to the basic systolic processing element: one MAC cell of the SlugTPU array supporting both weight-stationary (WS) and output-stationary (OS) dataflows. It adds double-buffered weights with a column-wide swap, a wide saturating accumulator with a sticky overflow flag, and a local accumulator that drains down the psum chain. It tiles into an N×N grid: inputs flow east, weights, psums and swap flow south.

## Interface
- INPUT_WIDTH, 8, signed activation width
- WEIGHT_WIDTH, 8, signed weight width
- PSUM_WIDTH, 32, signed psum/accumulator width; must be ≥ INPUT_WIDTH+WEIGHT_WIDTH
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, synchronous, active-low
- mode_i  in  1  0 = WS, 1 = OS; quasi-static
- pe_clear_i  in  1  zero accumulator and overflow flag
- pe_drain_i  in  1  OS drain request, driven to a whole column simultaneously
- pe_input_i / pe_input_valid_i  in  INPUT_WIDTH / 1  west activation
- pe_input_o / pe_input_valid_o  out  INPUT_WIDTH / 1  east activation, registered
- pe_weight_i / pe_weight_valid_i  in  WEIGHT_WIDTH / 1  north weight
- pe_weight_o / pe_weight_valid_o  out  WEIGHT_WIDTH / 1  south weight (shadow register)
- pe_swap_i / pe_swap_o  in/out  1  shadow→active swap, forwarded south registered
- pe_psum_i / pe_psum_valid_i  in  PSUM_WIDTH / 1  north psum
- pe_psum_o / pe_psum_valid_o  out  PSUM_WIDTH / 1  south psum
- pe_ovf_o  out  1  sticky saturation/wrap event

## Operation
- Mode register: mode_i is registered every cycle. A change moves the FSM to S_WS or S_OS_ACC and clears acc/ovf on the next cycle. Changing mode while any valid is high is illegal.
- FSM states:
  - S_WS
  - S_OS_ACC: →S_OS_DRAIN when pe_drain_i=1
  - S_OS_DRAIN: stays while pe_drain_i=1, →S_OS_ACC when pe_drain_i=0
- Weight chain, both modes: when pe_weight_valid_i=1, w_sh ← pe_weight_i. pe_weight_o=w_sh and pe_weight_valid_o ← pe_weight_valid_i. N pushes load a column bottom-first.
- Swap: when pe_swap_i=1, w_act ← w_sh using the pre-update w_sh, even if a load occurs the same cycle. pe_swap_o ← pe_swap_i.
- WS MAC: pe_psum_o ← f(psum_in + pe_input_i·w_act), where psum_in = pe_psum_valid_i ? pe_psum_i : 0. pe_psum_valid_o ← pe_input_valid_i. When input is invalid, pe_psum_o holds its value.
- OS MAC: when pe_input_valid_i && pe_weight_valid_i, acc ← f(acc + pe_input_i·pe_weight_i).
- OS psum outputs:
  - In S_OS_ACC, pe_psum_valid_o=0.
  - On the S_OS_ACC→S_OS_DRAIN edge: pe_psum_o ← acc-result, valid ← 1, acc cleared. A MAC firing the same cycle is included in the emitted value.
  - In S_OS_DRAIN: pe_psum_o ← pe_psum_i, valid ← pe_psum_valid_i. A MAC during DRAIN accumulates into the new (cleared) acc.
- Arithmetic f:
  - Product is signed, INPUT_WIDTH+WEIGHT_WIDTH bits, sign-extended to PSUM_WIDTH+1; the sum is computed in PSUM_WIDTH+1 bits.
  - On overflow: clamp to [−2^(P−1), 2^(P−1)−1] if SATURATE, else truncate. In either case set pe_ovf_o.
- pe_clear_i: acc ← 0, ovf ← 0. It has priority over a same-cycle MAC (the MAC is discarded). It does not touch weights.
- Input chain: pe_input_o ← pe_input_i, pe_input_valid_o ← pe_input_valid_i unconditionally.

## Timing
- All outputs are registered; every chain (input, weight, swap, psum) has 1-cycle latency per PE.
- Reset (rst_ni=0 at a clock edge) sets:
  - outputs: all zero
  - internal: w_sh=w_act=acc=0, mode=WS, FSM=S_WS
- Reset mid-drain aborts the drain with no emitted value.
- Column drain: pe_drain_i is held high for R cycles (R = rows). The bottom PE emits acc[R−1], acc[R−2], …, acc[0] on R consecutive cycles.
- The swap reaches row k k cycles after row 0. The controller skews inputs to match.

## Structure
- pe_pkg contains:
  - pe_mode_e {PE_MODE_WS, PE_MODE_OS}
  - pe_state_e {S_WS, S_OS_ACC, S_OS_DRAIN}
  - localparam defaults
- One sub-module: pe_sat_add (combinational signed add with SATURATE clamp and overflow out), shared by the WS and OS paths.

## Test plan
- WS basic:
  - Stimulus: load w=3, swap, then input −4 with psum_i=100 valid.
  - Required: psum_o=88, valid=1 one cycle later.
- Swap/load race:
  - Stimulus: w_sh=5, then a cycle with load w=9 and swap both high, then input 2.
  - Required: psum uses 5 (psum_o=10); weight_o=9.
- Saturation:
  - Stimulus: PSUM_WIDTH=16, SATURATE=1, psum_i=32760, input 127·weight 127.
  - Required: psum_o=32767, ovf=1.
  - With SATURATE=0: psum_o = wrapped value, ovf=1.
- OS accumulate+drain:
  - Stimulus: 4 MACs (1·1, 2·2, 3·3, 4·4), then drain high for 3 cycles with psum_i=7,8 valid.
  - Required: psum_o sequence 30, 7, 8, valid each cycle; acc=0 afterwards.
- Clear priority:
  - Stimulus: clear and MAC 5·5 in the same cycle.
  - Required: acc=0, ovf=0.
- Reset mid-drain:
  - Stimulus: rst_ni=0 during S_OS_DRAIN.
  - Required: all outputs 0 next cycle; mode=WS.
